reg_bank: RTL
=============

// Module: reg_bank
// PURPOSE
//   32 x DATA_W general-purpose register file; consumer side of the destination-register select path.
//   Write port takes the selected destination index (rt / rd / $sp / $ra / rs) plus write-back data from the datapath.
//   Two read ports (A = rs, B = rt) feed the ALU-operand registers of the multicycle core.
//   Reads are registered: each port's output updates on the clock edge after its address is presented.
// PARAMETERS
//   DATA_W    32        register width in bits
//   SP_RESET  32'd227   value loaded into $sp (r29) on reset
//   RA_RESET  32'd0     value loaded into $ra (r31) on reset
// PORTS
//   clk        in   1       core clock; all state updates on rising edge
//   reset_n    in   1       asynchronous, active-low reset
//   rd_addr_a  in   5       read port A index (instr[25:21])
//   rd_addr_b  in   5       read port B index (instr[20:16])
//   wr_en      in   1       write strobe, sampled at rising edge
//   wr_addr    in   5       destination index from destination-register select
//   wr_data    in   DATA_W  write-back data
//   rd_data_a  out  DATA_W  registered read data, port A
//   rd_data_b  out  DATA_W  registered read data, port B
// BEHAVIOUR
//   Reset (reset_n=0, asynchronous):
//     - r29 = SP_RESET; r31 = RA_RESET; all other regs = 0.
//     - rd_data_a = rd_data_b = 0.
//     - Held for as long as reset_n=0.
//   Release: first active edge is the first rising clk with reset_n=1; no synchronizer inside the block.
//   Write:
//     - At rising edge, if wr_en=1 and wr_addr!=0: regs[wr_addr] <= wr_data.
//     - Write to r0 is silently dropped; r0 always reads 0.
//   Read latency 1: at each rising edge, rd_data_x <= value(rd_addr_x). No enable; ports update every cycle.
//   Same-cycle write/read to the same index (wr_en=1, wr_addr==rd_addr_x!=0): see BYPASS_EN.
//   Both ports on the same index: both return an identical value.
//   wr_addr==0 with rd_addr_x==0: rd_data_x = 0 regardless of BYPASS_EN.
//   wr_en=0: wr_addr/wr_data are ignored, even if X.
//   Reset asserted mid-write: reset wins; the write is lost and the reset values above apply.
//   No overflow or width conversion: wr_data is stored verbatim.
// CONFIGURATION
//   REG_BANK_BYPASS_EN defined:
//     - Same-cycle colliding read returns the new wr_data (write-first).
//   REG_BANK_BYPASS_EN undefined:
//     - Same-cycle colliding read returns the pre-write contents (read-first).
//     - The new value is visible one cycle later.
//   Either way, stored contents after the edge are identical.
// STRUCTURE
//   Shared package reg_pkg:
//     - typedef logic [4:0] reg_addr_t
//     - localparams REG_ZERO=5'd0, REG_SP=5'd29, REG_RA=5'd31
//     - regDST select encoding enum
//   Storage: one always_ff with asynchronous reset.
//   Sub-module reg_read_port, instantiated twice:
//     - address decode, zero-index masking, optional bypass compare, output register.
// TESTING
//   1. Reset:
//      - reset_n=0 mid-cycle -> rd_data_a/b=0 immediately.
//      - After release, read r29 -> 227; read r31 -> 0; read r5 -> 0.
//   2. Write/read:
//      - Write r8=32'hDEADBEEF; next cycle rd_addr_a=8 -> one edge later rd_data_a=32'hDEADBEEF.
//      - rd_addr_b=8 in the same cycle -> same value.
//   3. r0:
//      - Write r0=32'hFFFFFFFF -> reads of r0 on both ports stay 0.
//   4. Collision, r9 holding 32'h1111 and written 32'h2222 with rd_addr_a=9 same cycle:
//      - BYPASS_EN defined -> rd_data_a=32'h2222.
//      - BYPASS_EN undefined -> rd_data_a=32'h1111, then 32'h2222 on the next edge.
//   5. Reset mid-write:
//      - wr_en=1, wr_addr=29, wr_data=5, with reset_n dropped before the edge -> r29 reads 227 after release.
//   6. Sweep:
//      - Write regs 1..31 with value {27'b0, idx}, read all 31 back on both ports -> exact match; wr_en=0 cycles change nothing.

Source files
------------

// File: rtl/reg_pkg.sv
// Shared register-file definitions: index type, architectural register numbers
// and the destination-register select encoding used by the write-back path.
package reg_pkg;

    localparam int REG_COUNT = 32;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_SP   = 5'd29;
    localparam reg_addr_t REG_RA   = 5'd31;

    typedef enum logic [2:0] {
        REGDST_RT = 3'd0,
        REGDST_RD = 3'd1,
        REGDST_SP = 3'd2,
        REGDST_RA = 3'd3,
        REGDST_RS = 3'd4
    } regdst_e;

    function automatic logic reg_is_zero(input reg_addr_t addr);
        return (addr == REG_ZERO);
    endfunction

endpackage

// File: rtl/reg_read_port.sv
// One registered read port of the register file: selects an entry, forces r0
// to zero and, when BYPASS_EN is set, forwards a same-edge write (write-first).
module reg_read_port
    import reg_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter bit BYPASS_EN = 1'b0
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [REG_COUNT-1:0][DATA_W-1:0] i_regs,
    input  reg_addr_t                        i_rd_addr,
    input  logic                             i_wr_en,
    input  reg_addr_t                        i_wr_addr,
    input  logic [DATA_W-1:0]                i_wr_data,
    output logic [DATA_W-1:0]                o_rd_data
);

    logic              w_hit;
    logic [DATA_W-1:0] w_next;
    logic [DATA_W-1:0] r_rd_data;

    // Next read value: zero index first, then optional forwarding, else storage
    always_comb begin
        w_hit  = BYPASS_EN && i_wr_en && (i_wr_addr == i_rd_addr);
        w_next = '0;
        if (reg_is_zero(i_rd_addr)) begin
            w_next = '0;
        end else if (w_hit) begin
            w_next = i_wr_data;
        end else begin
            w_next = i_regs[i_rd_addr];
        end
    end

    // Output register, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_next;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/reg_bank.sv
// 32-entry register file with one write port and two registered read ports.
// Define REG_BANK_BYPASS_EN for write-first collisions; default is read-first.
module reg_bank
    import reg_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] SP_RESET = 32'd227,
    parameter logic [DATA_W-1:0] RA_RESET = 32'd0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [4:0]        rd_addr_a,
    input  logic [4:0]        rd_addr_b,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

`ifdef REG_BANK_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic [REG_COUNT-1:0][DATA_W-1:0] r_regs;

    // Register storage; r0 is never written so it stays at its reset zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
            r_regs[REG_SP] <= SP_RESET;
            r_regs[REG_RA] <= RA_RESET;
        end else if (wr_en && !reg_is_zero(wr_addr)) begin
            r_regs[wr_addr] <= wr_data;
        end else begin
            r_regs <= r_regs;
        end
    end

    reg_read_port #(
        .DATA_W   (DATA_W),
        .BYPASS_EN(BYPASS_EN)
    ) u_port_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_regs   (r_regs),
        .i_rd_addr(rd_addr_a),
        .i_wr_en  (wr_en),
        .i_wr_addr(wr_addr),
        .i_wr_data(wr_data),
        .o_rd_data(rd_data_a)
    );

    reg_read_port #(
        .DATA_W   (DATA_W),
        .BYPASS_EN(BYPASS_EN)
    ) u_port_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_regs   (r_regs),
        .i_rd_addr(rd_addr_b),
        .i_wr_en  (wr_en),
        .i_wr_addr(wr_addr),
        .i_wr_data(wr_data),
        .o_rd_data(rd_data_b)
    );

endmodule
